// File: rtl/vga_frame_scanout.sv
// 160x120x3 frame buffer with an independent write port. The buffer is scanned out as VGA
// with each stored pixel replicated 2^SCALE_SHIFT times in both directions.
module vga_frame_scanout #(
  parameter int unsigned H_VISIBLE      = 640,
  parameter int unsigned H_FRONT        = 16,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BACK         = 48,
  parameter int unsigned V_VISIBLE      = 480,
  parameter int unsigned V_FRONT        = 10,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BACK         = 33,
  parameter int unsigned SCALE_SHIFT    = 2,
  parameter int unsigned CLKS_PER_PIXEL = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       write_dropped,
  output logic       frame_start,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk
);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned PW      = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int unsigned FB_COLS = 160;
  localparam int unsigned FB_ROWS = 120;
  localparam int unsigned FB_SIZE = FB_COLS * FB_ROWS;
  localparam int unsigned AW      = 15;

  logic [PW-1:0] phase_q, phase_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          pix_en, h_last, v_last;

  logic [2:0]    rd_q, rd_d;
  logic          hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic          write_dropped_q, write_dropped_d;

  logic [2:0]    fb_mem [FB_SIZE];
  logic          scan_visible, scan_hs_n, scan_vs_n;
  logic [AW-1:0] rd_row, rd_col, rd_addr;
  logic [AW-1:0] wr_row, wr_col, wr_addr;
  logic          wr_in_range, wr_en;
  logic [2:0]    fb_rd_data;

  assign pix_en = (phase_q == PW'(CLKS_PER_PIXEL - 1));
  assign h_last = (h_q == HW'(H_TOTAL - 1));
  assign v_last = (v_q == VW'(V_TOTAL - 1));

  assign scan_visible = (h_q < HW'(H_VISIBLE)) && (v_q < VW'(V_VISIBLE));
  assign scan_hs_n = !((h_q >= HW'(H_VISIBLE + H_FRONT)) &&
                       (h_q <  HW'(H_VISIBLE + H_FRONT + H_SYNC)));
  assign scan_vs_n = !((v_q >= VW'(V_VISIBLE + V_FRONT)) &&
                       (v_q <  VW'(V_VISIBLE + V_FRONT + V_SYNC)));

  // Off-screen counter values are gated to address 0 so the read index stays inside the buffer.
  assign rd_row  = scan_visible ? AW'(v_q >> SCALE_SHIFT) : '0;
  assign rd_col  = scan_visible ? AW'(h_q >> SCALE_SHIFT) : '0;
  assign rd_addr = (rd_row << 7) + (rd_row << 5) + rd_col;

  assign wr_in_range = (x < 8'(FB_COLS)) && (y < 7'(FB_ROWS));
  assign wr_en       = plot && wr_in_range;
  assign wr_row      = AW'(y);
  assign wr_col      = AW'(x);
  assign wr_addr     = (wr_row << 7) + (wr_row << 5) + wr_col;

  // Buffer has no reset; the scan read samples the pre-edge contents (read-before-write).
  always_ff @(posedge clock) begin
    if (wr_en) begin
      fb_mem[wr_addr] <= colour;
    end
  end

  assign fb_rd_data = fb_mem[rd_addr];

  always_comb begin
    phase_d         = phase_q + PW'(1);
    h_d             = h_q;
    v_d             = v_q;
    rd_d            = rd_q;
    hs1_d           = hs1_q;
    vs1_d           = vs1_q;
    vis1_d          = vis1_q;
    rgb_d           = rgb_q;
    hs_d            = hs_q;
    vs_d            = vs_q;
    blank_n_d       = blank_n_q;
    write_dropped_d = plot && !wr_in_range;
    if (pix_en) begin
      phase_d   = '0;
      h_d       = h_last ? '0 : h_q + HW'(1);
      if (h_last) begin
        v_d = v_last ? '0 : v_q + VW'(1);
      end
      rd_d      = fb_rd_data;
      hs1_d     = scan_hs_n;
      vs1_d     = scan_vs_n;
      vis1_d    = scan_visible;
      rgb_d     = vis1_q ? rd_q : 3'b000;
      hs_d      = hs1_q;
      vs_d      = vs1_q;
      blank_n_d = vis1_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase_q         <= '0;
      h_q             <= '0;
      v_q             <= '0;
      rd_q            <= '0;
      hs1_q           <= 1'b1;
      vs1_q           <= 1'b1;
      vis1_q          <= 1'b0;
      rgb_q           <= '0;
      hs_q            <= 1'b1;
      vs_q            <= 1'b1;
      blank_n_q       <= 1'b0;
      write_dropped_q <= 1'b0;
    end else begin
      phase_q         <= phase_d;
      h_q             <= h_d;
      v_q             <= v_d;
      rd_q            <= rd_d;
      hs1_q           <= hs1_d;
      vs1_q           <= vs1_d;
      vis1_q          <= vis1_d;
      rgb_q           <= rgb_d;
      hs_q            <= hs_d;
      vs_q            <= vs_d;
      blank_n_q       <= blank_n_d;
      write_dropped_q <= write_dropped_d;
    end
  end

  assign frame_start   = pix_en && h_last && v_last;
  assign write_dropped = write_dropped_q;
  assign vga_r         = {8{rgb_q[2]}};
  assign vga_g         = {8{rgb_q[1]}};
  assign vga_b         = {8{rgb_q[0]}};
  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign vga_blank_n   = blank_n_q;
  assign vga_sync_n    = 1'b0;
  assign vga_clk       = (phase_q < PW'(CLKS_PER_PIXEL / 2));

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Bench for vga_frame_scanout on a compact screen geometry. A time-based reference model
// predicts every pin from the elapsed clock count and a shadow copy of the frame buffer.
module tb_vga_frame_scanout;
  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 48, VF = 2, VS = 2, VB = 2;
  localparam int SS = 2, CPP = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FB = 19200;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       plot = 1'b0;
  logic       write_dropped, frame_start, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;
  logic [7:0] vga_r, vga_g, vga_b;

  always #5 clock = ~clock;

  vga_frame_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SCALE_SHIFT(SS), .CLKS_PER_PIXEL(CPP)
  ) dut (
    .clock(clock), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
    .write_dropped(write_dropped), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .vga_clk(vga_clk)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Shadow buffer; an entry is only compared once the bench has written it.
  logic [2:0] m_mem [FB];
  bit         m_known [FB];
  // Expected pin word: {care, blank_n, vs, hs, rgb}
  logic [6:0] exp_q[$];
  logic [6:0] cur;
  logic       exp_drop;
  int         m_t;

  function automatic logic [6:0] predict(input int t);
    int p, h, v, a;
    logic vis, hs_n, vs_n, care;
    logic [2:0] c;
    p    = t / 2;
    h    = p % HT;
    v    = (p / HT) % VT;
    vis  = (h < HV) && (v < VV);
    hs_n = !(h >= HV + HF && h < HV + HF + HS);
    vs_n = !(v >= VV + VF && v < VV + VF + VS);
    a    = (v >> SS) * 160 + (h >> SS);
    c    = 3'b000;
    care = 1'b1;
    if (vis) begin
      c    = m_mem[a];
      care = m_known[a];
    end
    return {care, vis, vs_n, hs_n, c};
  endfunction

  always @(negedge clock) begin
    if (!resetn) begin
      m_t      = 0;
      exp_q.delete();
      cur      = 7'b1_0_1_1_000;
      exp_drop = 1'b0;
      check_eq("rst_hold_pins", 32'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
                                     frame_start, write_dropped, vga_clk}),
               32'({24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}));
    end else begin
      begin
        int p;
        logic fs;
        p  = m_t / 2;
        fs = (m_t % 2 == 1) && (p % HT == HT - 1) && ((p / HT) % VT == VT - 1);
        check_eq("sync", 32'({vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk}),
                 32'({cur[3], cur[4], cur[5], 1'b0, (m_t % 2 == 0)}));
        if (cur[6])
          check_eq("rgb", 32'({vga_r, vga_g, vga_b}),
                   32'({{8{cur[2]}}, {8{cur[1]}}, {8{cur[0]}}}));
        check_eq("frame_start", 32'(frame_start), 32'(fs));
        check_eq("write_dropped", 32'(write_dropped), 32'(exp_drop));
      end
      // Effect of the coming edge: scan read sees the buffer before this edge's write.
      if (m_t % 2 == 1) begin
        exp_q.push_back(predict(m_t));
        if (exp_q.size() == 2) cur = exp_q.pop_front();
      end
      exp_drop = plot && (x >= 8'd160 || y >= 7'd120);
      if (plot && x < 8'd160 && y < 7'd120) begin
        m_mem[int'(y) * 160 + int'(x)]   = colour;
        m_known[int'(y) * 160 + int'(x)] = 1'b1;
      end
      m_t++;
    end
  end

  task automatic drive(input int px, input int py, input int pc, input bit pp);
    @(posedge clock);
    #1;
    x      = 8'(px);
    y      = 7'(py);
    colour = 3'(pc);
    plot   = pp;
  endtask

  initial begin
    int k, lo, hi;
    bit found;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    for (int i = 0; i < FB; i++) drive(i % 160, i / 160, 3'b011, 1'b1);
    drive(0, 0, 0, 1'b0);
    repeat (2 * HT * VT + 8) @(posedge clock);

    drive(160, 0, 7, 1'b1);
    drive(0, 120, 7, 1'b1);
    drive(159, 119, 5, 1'b1);
    drive(255, 127, 1, 1'b1);
    drive(3, 2, 4, 1'b1);
    drive(0, 0, 0, 1'b0);

    for (int i = 0; i < 2 * HT * VT; i++) begin
      if ($urandom_range(0, 1) == 1)
        drive($urandom_range(0, (HV >> SS) - 1), $urandom_range(0, (VV >> SS) - 1),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      else
        drive($urandom_range(0, 255), $urandom_range(0, 127),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end
    drive(0, 0, 0, 1'b0);

    found = 1'b0;
    for (int i = 0; i < 4 * HT && !found; i++) begin
      @(posedge clock);
      #1;
      if (m_t % 2 == 1) begin
        int p, h, v;
        p = m_t / 2;
        h = p % HT;
        v = (p / HT) % VT;
        if (h < HV && v < VV) begin
          x      = 8'(h >> SS);
          y      = 7'(v >> SS);
          colour = ~m_mem[(v >> SS) * 160 + (h >> SS)];
          plot   = 1'b1;
          found  = 1'b1;
        end
      end
    end
    check_eq("collision_slot_found", 32'(found), 32'd1);
    drive(0, 0, 0, 1'b0);
    repeat (2 * HT * VT + 8) @(posedge clock);

    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_async_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check_eq("rst_async_sync", 32'({vga_hs, vga_vs, vga_blank_n, vga_clk}), 32'b1101);
    check_eq("rst_async_pulses", 32'({frame_start, write_dropped}), 32'd0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;

    k = 0;
    while (k < 3 * HT * VT) begin
      @(negedge clock);
      if (frame_start === 1'b1) break;
      k++;
    end
    check_eq("first_frame_start_clks", 32'(k + 1), 32'(2 * HT * VT));

    k = 0;
    while (vga_hs !== 1'b0 && k < 4 * HT) begin @(negedge clock); k++; end
    lo = 0;
    while (vga_hs === 1'b0 && lo < 4 * HT) begin lo++; @(negedge clock); end
    hi = 0;
    while (vga_hs === 1'b1 && hi < 4 * HT) begin hi++; @(negedge clock); end
    check_eq("hs_low_clks", 32'(lo), 32'(2 * HS));
    check_eq("line_clks", 32'(lo + hi), 32'(2 * HT));

    k = 0;
    while (vga_vs !== 1'b0 && k < 3 * HT * VT) begin @(negedge clock); k++; end
    lo = 0;
    while (vga_vs === 1'b0 && lo < 3 * HT * VT) begin lo++; @(negedge clock); end
    check_eq("vs_low_clks", 32'(lo), 32'(2 * HT * VS));

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
